// File: rtl/pe_pkg.sv
// Shared parameters and types for the PE array output stage.
//   WIDTH          : signed psum / threshold width
//   OUT_ROW_LENGTH : pixels delivered per channel pop
//   O_CH           : output channels per layer pass (multiple of OUT_W)
//   OUT_W          : packed output word width
package pe_pkg;

   localparam int unsigned WIDTH          = 14;
   localparam int unsigned OUT_ROW_LENGTH = 10;
   localparam int unsigned O_CH           = 64;
   localparam int unsigned OUT_W          = 16;

   localparam int unsigned WORDS_PER_PIX  = O_CH / OUT_W;

   // Counter widths, never narrower than one bit
   localparam int unsigned CH_CNT_W   = (O_CH > 1)           ? $clog2(O_CH)           : 1;
   localparam int unsigned PIX_CNT_W  = (OUT_ROW_LENGTH > 1) ? $clog2(OUT_ROW_LENGTH) : 1;
   localparam int unsigned WORD_CNT_W = (WORDS_PER_PIX > 1)  ? $clog2(WORDS_PER_PIX)  : 1;

   // Folded batch-norm threshold entry; layout matches thr_in {inv, thr}
   typedef struct packed {
      logic                    inv;
      logic signed [WIDTH-1:0] thr;
   } thr_entry_t;

endpackage

// File: rtl/psum_thresh_cmp.sv
// Binarizes one channel row of psums against a single threshold.
//   psum_in  : OUT_ROW_LENGTH packed two's-complement psums, pixel i at [i*WIDTH +: WIDTH]
//   thr_in   : signed threshold for this channel
//   inv_in   : flip the comparison result
//   bits_out : bit i = (psum_i >= thr_in) XOR inv_in
module psum_thresh_cmp
   import pe_pkg::*;
(
   input  logic [OUT_ROW_LENGTH*WIDTH-1:0] psum_in,
   input  logic signed [WIDTH-1:0]         thr_in,
   input  logic                            inv_in,
   output logic [OUT_ROW_LENGTH-1:0]       bits_out
);

   // Full-width signed compare; equality binarizes to 1 before inversion
   for (genvar p = 0; p < OUT_ROW_LENGTH; p++) begin : g_cmp
      logic signed [WIDTH-1:0] psum_c;
      assign psum_c      = $signed(psum_in[p*WIDTH +: WIDTH]);
      assign bits_out[p] = (psum_c >= thr_in) ^ inv_in;
   end

endmodule

// File: rtl/psum_binarizer.sv
// Binarizes per-channel psum rows from the PE array and transposes them into a
// ping-pong channel-by-pixel buffer, drained as channel-packed activation words.
//   clk_in, rst_in             : clock, synchronous active-low reset
//   thr_load_in, thr_in        : shift one {inv, thr} entry into the threshold chain
//   psum_valid_in/ready_out    : one channel row per accept, channels in order 0..O_CH-1
//   psum_in                    : OUT_ROW_LENGTH packed signed psums
//   act_valid_out/act_ready_in : output word handshake
//   act_out                    : bit b = channel w*OUT_W+b of the current pixel
module psum_binarizer
   import pe_pkg::*;
(
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            thr_load_in,
   input  logic [WIDTH:0]                  thr_in,
   input  logic                            psum_valid_in,
   output logic                            psum_ready_out,
   input  logic [OUT_ROW_LENGTH*WIDTH-1:0] psum_in,
   output logic                            act_valid_out,
   input  logic                            act_ready_in,
   output logic [OUT_W-1:0]                act_out
);

   thr_entry_t thr_q [O_CH];

   // bank_q[bank][pixel] holds one bit per channel
   logic [O_CH-1:0] bank_q [2][OUT_ROW_LENGTH];

   logic [1:0]            full_q, full_d;
   logic                  fill_ptr_q, fill_ptr_d;
   logic                  drain_ptr_q, drain_ptr_d;
   logic [CH_CNT_W-1:0]   ch_cnt_q, ch_cnt_d;
   logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

   logic                      accept_c;
   logic                      xfer_c;
   logic                      last_ch_c;
   logic                      last_word_c;
   thr_entry_t                thr_sel_c;
   logic [OUT_ROW_LENGTH-1:0] cmp_bits_c;
   logic [CH_CNT_W-1:0]       word_base_c;
   logic [OUT_W-1:0]          act_word_c;

   // Handshake status comes only from registered flags plus the load strobe
   assign psum_ready_out = !full_q[fill_ptr_q] && !thr_load_in;
   assign act_valid_out  = full_q[drain_ptr_q];

   assign accept_c    = psum_valid_in && psum_ready_out;
   assign xfer_c      = act_valid_out && act_ready_in;
   assign last_ch_c   = (ch_cnt_q == CH_CNT_W'(O_CH - 1));
   assign last_word_c = (pix_cnt_q == PIX_CNT_W'(OUT_ROW_LENGTH - 1)) &&
                        (word_cnt_q == WORD_CNT_W'(WORDS_PER_PIX - 1));

   assign thr_sel_c = thr_q[ch_cnt_q];

   psum_thresh_cmp u_cmp (
      .psum_in  (psum_in),
      .thr_in   (thr_sel_c.thr),
      .inv_in   (thr_sel_c.inv),
      .bits_out (cmp_bits_c)
   );

   // Output word: OUT_W consecutive channels of the current pixel, zero when idle
   assign word_base_c = CH_CNT_W'(32'(word_cnt_q) * OUT_W);
   assign act_word_c  = bank_q[drain_ptr_q][pix_cnt_q][word_base_c +: OUT_W];
   assign act_out     = act_valid_out ? act_word_c : '0;

   // Threshold shift chain: newest entry enters at the top channel
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int k = 0; k < O_CH; k++) begin
            thr_q[CH_CNT_W'(k)] <= '0;
         end
      end else if (thr_load_in) begin
         for (int k = 0; k < O_CH - 1; k++) begin
            thr_q[CH_CNT_W'(k)] <= thr_q[CH_CNT_W'(k + 1)];
         end
         thr_q[O_CH-1] <= thr_entry_t'(thr_in);
      end
   end

   // Bit transpose into the fill bank; contents are qualified by full_q, so no reset
   always_ff @(posedge clk_in) begin
      if (accept_c) begin
         for (int p = 0; p < OUT_ROW_LENGTH; p++) begin
            bank_q[fill_ptr_q][PIX_CNT_W'(p)][ch_cnt_q] <= cmp_bits_c[PIX_CNT_W'(p)];
         end
      end
   end

   // Next-state for bank flags, pointers and counters
   always_comb begin
      full_d      = full_q;
      fill_ptr_d  = fill_ptr_q;
      drain_ptr_d = drain_ptr_q;
      ch_cnt_d    = ch_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      word_cnt_d  = word_cnt_q;

      if (accept_c) begin
         if (last_ch_c) begin
            full_d[fill_ptr_q] = 1'b1;
            fill_ptr_d         = !fill_ptr_q;
            ch_cnt_d           = '0;
         end else begin
            ch_cnt_d = ch_cnt_q + CH_CNT_W'(1);
         end
      end

      // Fill and drain always target different banks, so both updates apply
      if (xfer_c) begin
         if (last_word_c) begin
            full_d[drain_ptr_q] = 1'b0;
            drain_ptr_d         = !drain_ptr_q;
            pix_cnt_d           = '0;
            word_cnt_d          = '0;
         end else if (word_cnt_q == WORD_CNT_W'(WORDS_PER_PIX - 1)) begin
            word_cnt_d = '0;
            pix_cnt_d  = pix_cnt_q + PIX_CNT_W'(1);
         end else begin
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         full_q      <= '0;
         fill_ptr_q  <= 1'b0;
         drain_ptr_q <= 1'b0;
         ch_cnt_q    <= '0;
         pix_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         full_q      <= full_d;
         fill_ptr_q  <= fill_ptr_d;
         drain_ptr_q <= drain_ptr_d;
         ch_cnt_q    <= ch_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_psum_binarizer.sv
// Self-checking bench for psum_binarizer: a channel/pixel reference model builds
// the expected word stream, a negedge monitor checks every transfer against it.
module tb_psum_binarizer;
   import pe_pkg::*;

   logic                            clk_in = 1'b0;
   logic                            rst_in;
   logic                            thr_load_in;
   logic [WIDTH:0]                  thr_in;
   logic                            psum_valid_in;
   logic                            psum_ready_out;
   logic [OUT_ROW_LENGTH*WIDTH-1:0] psum_in;
   logic                            act_valid_out;
   logic                            act_ready_in;
   logic [OUT_W-1:0]                act_out;

   psum_binarizer dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .thr_load_in    (thr_load_in),
      .thr_in         (thr_in),
      .psum_valid_in  (psum_valid_in),
      .psum_ready_out (psum_ready_out),
      .psum_in        (psum_in),
      .act_valid_out  (act_valid_out),
      .act_ready_in   (act_ready_in),
      .act_out        (act_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: thresholds as loaded, current layer psums
   int lay   [O_CH][OUT_ROW_LENGTH];
   int m_thr [O_CH];
   bit m_inv [O_CH];

   logic [OUT_W-1:0] exp_q [$];
   logic [OUT_W-1:0] got_q [$];

   logic             prev_hold = 1'b0;
   logic [OUT_W-1:0] prev_word = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      $display("FAIL %s: timed out", name);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Expected output words for the current layer: pixel-major, OUT_W channels per word
   function automatic void model_layer();
      for (int p = 0; p < OUT_ROW_LENGTH; p++) begin
         for (int w = 0; w < WORDS_PER_PIX; w++) begin
            logic [OUT_W-1:0] wd;
            wd = '0;
            for (int b = 0; b < OUT_W; b++) begin
               int ch;
               bit v;
               ch = w * OUT_W + b;
               v  = (lay[ch][p] >= m_thr[ch]) ^ m_inv[ch];
               if (v) wd = wd | (OUT_W'(1) << b);
            end
            exp_q.push_back(wd);
         end
      end
   endfunction

   task automatic load_thr();
      for (int c = 0; c < O_CH; c++) begin
         thr_load_in = 1'b1;
         thr_in      = {m_inv[c], WIDTH'(m_thr[c])};
         #1;
         if (c == 0) chk("ready_during_load", 32'(psum_ready_out), 0);
         tick();
      end
      thr_load_in = 1'b0;
   endtask

   task automatic push_layer(output int stalls);
      int guard;
      model_layer();
      stalls = 0;
      for (int c = 0; c < O_CH; c++) begin
         psum_valid_in = 1'b1;
         for (int p = 0; p < OUT_ROW_LENGTH; p++)
            psum_in[p*WIDTH +: WIDTH] = WIDTH'(lay[c][p]);
         #1;
         guard = 0;
         while (!psum_ready_out) begin
            tick();
            stalls++;
            if (++guard > 3000) timeout_fail("push_stall");
         end
         tick();
      end
      psum_valid_in = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (exp_q.size() != 0) begin
         tick();
         if (++guard > 2000) timeout_fail("drain_wait");
      end
   endtask

   // Transfer monitor: order/value against the model, plus stability under backpressure
   always @(negedge clk_in) begin
      if (!rst_in) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 32'(act_valid_out), 1);
            chk("hold_word", 32'(act_out), 32'(prev_word));
         end
         if (act_valid_out && act_ready_in) begin
            got_q.push_back(act_out);
            if (exp_q.size() == 0) chk("unexpected_word", 32'(act_out), 32'hDEAD_BEEF);
            else chk("word", 32'(act_out), 32'(exp_q.pop_front()));
         end
         prev_hold = act_valid_out && !act_ready_in;
         prev_word = act_out;
      end
   end

   initial begin
      int st, tot, k, cyc, base;
      logic [OUT_W-1:0] snap;
      int bthr [4] = '{-8192, 8191, 8191, 8191};
      int bps  [4] = '{-8192, 8191, 8190, -8192};
      int bexp [4] = '{1, 1, 0, 0};

      rst_in = 1'b0; thr_load_in = 1'b0; thr_in = '0;
      psum_valid_in = 1'b0; psum_in = '0; act_ready_in = 1'b1;
      tick(); tick();
      chk("rst_valid", 32'(act_valid_out), 0);
      chk("rst_act", 32'(act_out), 0);
      chk("rst_ready", 32'(psum_ready_out), 1);
      rst_in = 1'b1;
      tick();

      // Reset thresholds (0/0); channel c psum = c-32
      for (int c = 0; c < O_CH; c++) begin
         m_thr[c] = 0; m_inv[c] = 0;
         for (int p = 0; p < OUT_ROW_LENGTH; p++) lay[c][p] = c - 32;
      end
      base = got_q.size();
      push_layer(st);
      chk("latency_valid", 32'(act_valid_out), 1);
      wait_drain();
      for (int w = 0; w < WORDS_PER_PIX; w++) begin
         chk("t1_p0", 32'(got_q[base + w]), (w >= 2) ? 32'hFFFF : 32'h0);
         chk("t1_p9", 32'(got_q[base + 9*WORDS_PER_PIX + w]), (w >= 2) ? 32'hFFFF : 32'h0);
      end

      // Same psums, all inverted
      for (int c = 0; c < O_CH; c++) m_inv[c] = 1;
      load_thr();
      base = got_q.size();
      push_layer(st);
      wait_drain();
      for (int w = 0; w < WORDS_PER_PIX; w++)
         chk("t2_p0", 32'(got_q[base + w]), (w >= 2) ? 32'h0 : 32'hFFFF);

      // Signed boundaries on channel 0, seen at word 0 bit 0 of pixel i
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < O_CH; c++) begin
            m_thr[c] = (c == 0) ? bthr[i] : 0;
            m_inv[c] = 0;
            for (int p = 0; p < OUT_ROW_LENGTH; p++) lay[c][p] = (c == 0) ? bps[i] : 0;
         end
         load_thr();
         base = got_q.size();
         push_layer(st);
         wait_drain();
         chk("boundary", 32'(got_q[base + i*WORDS_PER_PIX]), bexp[i] ? 32'hFFFF : 32'hFFFE);
      end

      // Mixed thresholds for the remaining traffic
      for (int c = 0; c < O_CH; c++) begin
         m_thr[c] = ((c * 97) % 200) - 100;
         m_inv[c] = (c % 3 == 0);
      end
      load_thr();

      // Backpressure: two full layers with the sink stalled
      act_ready_in = 1'b0;
      for (int L = 0; L < 2; L++) begin
         for (int c = 0; c < O_CH; c++)
            for (int p = 0; p < OUT_ROW_LENGTH; p++)
               lay[c][p] = ((c*37 + p*53 + L*11) % 256) - 128;
         push_layer(st);
         chk("bp_stalls", 32'(st), 0);
         if (L == 0) snap = act_out;
      end
      chk("bp_ready_low", 32'(psum_ready_out), 0);
      chk("bp_valid", 32'(act_valid_out), 1);
      chk("bp_stable", 32'(act_out), 32'(snap));
      act_ready_in = 1'b1;
      k = 0; cyc = 0;
      while (k < 40) begin
         @(negedge clk_in);
         if (act_valid_out && act_ready_in) begin
            k++;
            if (k == 40) chk("bp_ready_before", 32'(psum_ready_out), 0);
         end
         @(posedge clk_in); #1;
         if (k == 40) chk("bp_ready_after", 32'(psum_ready_out), 1);
         if (++cyc > 300) timeout_fail("bp_drain");
      end
      wait_drain();

      // Ping-pong: three layers back to back, sink always ready
      tot = 0;
      for (int L = 0; L < 3; L++) begin
         for (int c = 0; c < O_CH; c++)
            for (int p = 0; p < OUT_ROW_LENGTH; p++)
               lay[c][p] = ((c*71 + p*29 + L*173) % 16384) - 8192;
         push_layer(st);
         tot += st;
      end
      chk("pp_stalls", 32'(tot), 0);
      wait_drain();

      // Reset after 17 words of a layer; thresholds 100/0 must not survive
      for (int c = 0; c < O_CH; c++) begin m_thr[c] = 100; m_inv[c] = 0; end
      load_thr();
      for (int c = 0; c < O_CH; c++)
         for (int p = 0; p < OUT_ROW_LENGTH; p++) lay[c][p] = c * 5 + p;
      push_layer(st);
      k = 0; cyc = 0;
      while (k < 17) begin
         @(negedge clk_in);
         if (act_valid_out && act_ready_in) k++;
         @(posedge clk_in); #1;
         if (++cyc > 300) timeout_fail("rst_drain");
      end
      rst_in = 1'b0; act_ready_in = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(act_valid_out), 0);
      chk("mid_rst_ready", 32'(psum_ready_out), 1);
      chk("mid_rst_act", 32'(act_out), 0);
      rst_in = 1'b1; act_ready_in = 1'b1;
      exp_q.delete();
      for (int c = 0; c < O_CH; c++) begin
         m_thr[c] = 0; m_inv[c] = 0;
         for (int p = 0; p < OUT_ROW_LENGTH; p++) lay[c][p] = 0;
      end
      tick();
      base = got_q.size();
      push_layer(st);
      wait_drain();
      chk("post_rst_first", 32'(got_q[base]), 32'hFFFF);
      chk("post_rst_last", 32'(got_q[base + 39]), 32'hFFFF);
      chk("post_rst_count", 32'(got_q.size() - base), 40);

      repeat (3) tick();
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/psum_binarizer.md
Name: psum_binarizer

Overview:
- Downstream consumer of the PE array output stage; sits between the array's per-channel psum pop and the chip output pins.
- Each accepted pop delivers one output channel's row of OUT_ROW_LENGTH signed partial sums.
- Each psum is binarized against a per-channel folded batch-norm threshold with an optional sign flip.
- Bits are transposed into a ping-pong channel-by-pixel buffer and drained as OUT_W-bit channel-packed words over a valid/ready handshake, ready to be the next layer's activations.

Parameters:
- WIDTH, 14: signed psum and threshold width.
- OUT_ROW_LENGTH, 10: psums (pixels) per pop.
- O_CH, 64: output channels per layer pass; must be a multiple of OUT_W.
- OUT_W, 16: output word width; there are O_CH/OUT_W words per pixel.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: synchronous active-low reset.
- thr_load_in, input, 1: shift one threshold entry into the threshold chain.
- thr_in, input, WIDTH+1: [WIDTH-1:0] signed threshold; [WIDTH] invert flag.
- psum_valid_in, input, 1: psum_in is valid (driven from the array's pop).
- psum_ready_out, output, 1: block can accept a channel row.
- psum_in, input, OUT_ROW_LENGTH*WIDTH: pixel i at [i*WIDTH +: WIDTH], two's complement.
- act_valid_out, output, 1: act_out is valid.
- act_ready_in, input, 1: downstream accepts act_out.
- act_out, output, OUT_W: bit b = channel w*OUT_W+b of the current pixel.

Behaviour:
- Reset (rst_in low at posedge):
  - all O_CH threshold entries become 0 with invert 0;
  - both bank full flags clear; fill_ptr = drain_ptr = bank 0;
  - channel, pixel and word counters are 0;
  - act_valid_out = 0, act_out = 0, psum_ready_out = 1 from the first cycle after reset.
  - Reset mid-fill or mid-drain discards all buffered data.
- Threshold chain:
  - On thr_load_in, entry[O_CH-1] <= thr_in and entry[k] <= entry[k+1].
  - After O_CH loads, the first word shifted in sits in channel 0.
  - When thr_load_in is low the chain holds.
  - psum_ready_out is forced 0 while thr_load_in is high.
- Accept condition: psum_valid_in && psum_ready_out.
  - psum_ready_out = !full[fill_ptr] && !thr_load_in.
  - Channel order is implicit: the first accept after reset or a bank switch is channel 0; the channel counter counts 0..O_CH-1.
- Binarize (combinational, same cycle as accept):
  - bit[p] = (psum[p] >= thr[ch]) XOR inv[ch], using a signed compare at full WIDTH with no saturation.
  - Equality gives 1 before inversion.
  - bank[fill_ptr][ch][p] <= bit[p] at the accepting edge.
- Bank completion:
  - On accepting ch = O_CH-1, full[fill_ptr] is set, fill_ptr toggles and the channel counter wraps to 0, all at that edge.
  - The next cycle accepts into the other bank if that bank is not full.
- Drain:
  - Drain is active when full[drain_ptr] = 1; act_valid_out = full[drain_ptr].
  - act_out is taken from the registered drain pointers (pixel p, word w). Order: p = 0..OUT_ROW_LENGTH-1 outer, w = 0..O_CH/OUT_W-1 inner, giving OUT_ROW_LENGTH*O_CH/OUT_W = 40 words by default.
  - Transfer happens on act_valid_out && act_ready_in; the pointers advance.
  - act_out and act_valid_out stay stable while act_ready_in is low.
  - On the last word, full[drain_ptr] clears, drain_ptr toggles, and the counters return to 0.
- Latency:
  - Last channel accepted at edge t gives act_valid_out = 1 in cycle t+1, provided the drain bank is that bank.
  - Back-to-back words need no bubbles, so throughput is one word per cycle.
- Simultaneous events:
  - Fill completion on one bank and drain completion on the other in the same edge are both honoured.
  - Completing a drain frees its bank for acceptance in the next cycle; psum_ready_out is registered-flag based, with no combinational path from act_ready_in.
- Both banks full: psum_ready_out = 0; psum_valid_in is held by the upstream side and no data is lost.

Decomposition:
- Package pe_pkg:
  - WIDTH, OUT_ROW_LENGTH, O_CH, OUT_W;
  - derived WORDS_PER_PIX = O_CH/OUT_W and CH_CNT_W/PIX_CNT_W/WORD_CNT_W as clog2 values;
  - threshold entry struct {inv, thr}.
- One sub-module, psum_thresh_cmp: OUT_ROW_LENGTH parallel signed compares plus XOR, purely combinational.
- Banks, counters and handshake logic stay in psum_binarizer.

Test Plan:
- Thresholds all 0 / inv 0, pixels of channel c = c-32 -> for each of 10 pixels the words are 0x0000, 0x0000, 0xFFFF, 0xFFFF.
- Same psums, inv=1 on all channels -> 0xFFFF, 0xFFFF, 0x0000, 0x0000 per pixel.
- Boundary, on channel 0 pixels 0..2:
  - thr=-8192, psum=-8192 -> bit 1;
  - thr=8191, psum=8191 -> 1;
  - thr=8191, psum=8190 -> 0;
  - 2's-complement compare is checked via word 0 bit 0 of pixels 0..2.
- Backpressure:
  - hold act_ready_in=0 while two full layers are pushed -> psum_ready_out drops after the 128th accept;
  - act_out stays stable;
  - releasing ready drains 80 words in order, and psum_ready_out re-asserts the cycle after word 40.
- Ping-pong: continuous psum_valid_in with act_ready_in=1 -> zero upstream stalls, and the output word stream matches the reference model bit-exactly across 3 layers.
- Reset mid-drain (after word 17) -> next cycle act_valid_out=0 and psum_ready_out=1; thresholds read as 0, so a new layer of all-zero psums yields all-0xFFFF words.
